// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, byte indexing and row-shift permutations
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic {SR_FWD = 1'b0, SR_INV = 1'b1} sr_mode_e;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} srows_state_e;

  // Column-major byte numbering; byte 0 occupies the top bits of the state.
  function automatic int unsigned byte_idx(input int unsigned col, input int unsigned row);
    return 4 * col + row;
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8 * byte_idx(c, r) -: 8] = s[127 - 8 * byte_idx((c + r) % 4, r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8 * byte_idx(c, r) -: 8] = s[127 - 8 * byte_idx((c + 4 - r) % 4, r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/srows_perm.sv
// rtl/srows_perm.sv - combinational ShiftRows / InvShiftRows selector
module srows_perm
  import aes_pkg::*;
(
  input  aes_state_t i_state,
  input  logic       i_inverse,
  output aes_state_t o_state
);

  sr_mode_e w_mode;

  assign w_mode  = i_inverse ? SR_INV : SR_FWD;
  assign o_state = (w_mode == SR_INV) ? inv_shift_rows(i_state) : shift_rows(i_state);

endmodule

// File: rtl/srows_multi.sv
// rtl/srows_multi.sv - multi-block in-place ShiftRows engine on a shared SRAM port
module srows_multi
  import aes_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int STRIDE       = 16,
  parameter int ADDR_W       = 16,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              inverse,
  output logic              busy,
  output logic              done,
  input  logic [127:0]      sramReadValue,
  output logic [127:0]      sramWriteValue,
  output logic              sramRead,
  output logic              sramWrite,
  output logic [ADDR_W-1:0] sramAddr
);

  localparam int LAT_W = 3;

  srows_state_e      r_state, w_next;
  logic [CNT_W-1:0]  r_rem;
  logic [ADDR_W-1:0] r_addr;
  logic [LAT_W-1:0]  r_lat;
  logic              r_inverse;
  aes_state_t        r_data;
  aes_state_t        w_perm;

  srows_perm u_perm (
    .i_state  (sramReadValue),
    .i_inverse(r_inverse),
    .o_state  (w_perm)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // The last block is detected before the decrement: r_rem == 1 means none remain.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (num_blocks == '0) ? S_DONE : S_RD;
      S_RD:   w_next = S_WAIT;
      S_WAIT: if (r_lat == '0) w_next = S_WR;
      S_WR:   w_next = (r_rem == CNT_W'(1)) ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rem     <= '0;
      r_addr    <= '0;
      r_lat     <= '0;
      r_inverse <= 1'b0;
      r_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_rem     <= num_blocks;
          r_addr    <= base_addr;
          r_inverse <= inverse;
        end
        S_RD:   r_lat <= LAT_W'(READ_LATENCY - 1);
        S_WAIT: begin
          if (r_lat != '0) r_lat  <= r_lat - LAT_W'(1);
          else             r_data <= w_perm;
        end
        S_WR: begin
          r_rem  <= r_rem - CNT_W'(1);
          r_addr <= r_addr + ADDR_W'(STRIDE);
        end
        S_DONE: r_data <= '0;
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign sramRead       = (r_state == S_RD);
  assign sramWrite      = (r_state == S_WR);
  assign sramAddr       = (r_state == S_RD || r_state == S_WAIT || r_state == S_WR) ? r_addr : '0;
  assign sramWriteValue = r_data;

endmodule
